// File: rtl/fm_rom_arbiter.sv
// Round-robin arbiter sharing one FM waveform ROM between two readers.
// Grant is combinational; the owner tag travels alongside the ROM's read latency.
module fm_rom_arbiter #(
  parameter int ADDR_W  = 11,
  parameter int DATA_W  = 14,
  parameter int ROM_LAT = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  output logic              gnt0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  output logic              gnt1,
  output logic [ADDR_W-1:0] rom_address,
  input  logic [DATA_W-1:0] rom_q,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid0,
  output logic              rd_valid1,
  output logic              busy
);

  logic               prio;
  logic [ROM_LAT-1:0] pipe_vld;
  logic [ROM_LAT-1:0] pipe_own;
  logic               any_gnt;

  // Requester 1 wins a collision only when the pointer favours it.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!reset) begin
      gnt0 = req0 & (~req1 | ~prio);
      gnt1 = req1 & (~req0 | prio);
    end
  end

  assign any_gnt = gnt0 | gnt1;

  always_comb begin
    rom_address = '0;
    if (gnt0)
      rom_address = addr0;
    else if (gnt1)
      rom_address = addr1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      prio     <= 1'b0;
      pipe_vld <= '0;
      pipe_own <= '0;
    end else begin
      if (any_gnt)
        prio <= gnt0;
      pipe_vld[0] <= any_gnt;
      pipe_own[0] <= gnt1;
      for (int k = 1; k < ROM_LAT; k++) begin
        pipe_vld[k] <= pipe_vld[k-1];
        pipe_own[k] <= pipe_own[k-1];
      end
    end
  end

  assign rd_data   = rom_q;
  assign rd_valid0 = pipe_vld[ROM_LAT-1] & ~pipe_own[ROM_LAT-1];
  assign rd_valid1 = pipe_vld[ROM_LAT-1] &  pipe_own[ROM_LAT-1];
  assign busy      = |pipe_vld;

endmodule

// File: tb/tb_fm_rom_arbiter.sv
// Bench for fm_rom_arbiter: behavioural ROM, queue-based reference model, directed and random traffic.
module tb_fm_rom_arbiter;
  localparam int ADDR_W  = 11;
  localparam int DATA_W  = 14;
  localparam int ROM_LAT = 2;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              req0 = 1'b0, req1 = 1'b0;
  logic [ADDR_W-1:0] addr0 = '0, addr1 = '0;
  logic              gnt0, gnt1;
  logic [ADDR_W-1:0] rom_address;
  logic [DATA_W-1:0] rom_q;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid0, rd_valid1, busy;

  fm_rom_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ROM_LAT(ROM_LAT)) dut (
    .clock(clock), .reset(reset),
    .req0(req0), .addr0(addr0), .gnt0(gnt0),
    .req1(req1), .addr1(addr1), .gnt1(gnt1),
    .rom_address(rom_address), .rom_q(rom_q), .rd_data(rd_data),
    .rd_valid0(rd_valid0), .rd_valid1(rd_valid1), .busy(busy)
  );

  always #5 clock = ~clock;

  // ROM with registered address and registered output: two clocks of latency.
  logic [DATA_W-1:0] rom_mem [0:(1<<ADDR_W)-1];
  logic [ADDR_W-1:0] rom_addr_q = '0;
  always @(posedge clock) begin
    rom_addr_q <= rom_address;
    rom_q      <= rom_mem[rom_addr_q];
  end

  typedef struct {
    int          owner;
    int          data;
    int          due;
  } rd_t;

  rd_t q[$];
  int  m_prio = 0;
  int  cyc    = 0;
  int  total  = 0;
  int  bad    = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // One clock: drive inputs, check outputs against the model, then advance the model past the edge.
  task automatic step(input logic r0, input int a0, input logic r1, input int a1,
                      input logic rst, output logic g0, output logic g1);
    int   winner;
    int   exp_addr;
    logic ev0, ev1;
    int   ed;
    rd_t  e;
    @(negedge clock);
    req0  = r0; addr0 = a0[ADDR_W-1:0];
    req1  = r1; addr1 = a1[ADDR_W-1:0];
    reset = rst;
    #1;
    winner = -1;
    if (!rst) begin
      if (r0 && r1)  winner = m_prio;
      else if (r0)   winner = 0;
      else if (r1)   winner = 1;
    end
    exp_addr = (winner == 0) ? a0 : (winner == 1) ? a1 : 0;
    check_val("gnt0", gnt0, winner == 0);
    check_val("gnt1", gnt1, winner == 1);
    check_val("rom_address", rom_address, exp_addr & ((1<<ADDR_W)-1));
    check_val("busy", busy, q.size() > 0);
    ev0 = 1'b0; ev1 = 1'b0; ed = 0;
    if (q.size() > 0 && q[0].due == cyc) begin
      e   = q.pop_front();
      ev0 = (e.owner == 0);
      ev1 = (e.owner == 1);
      ed  = e.data;
    end
    check_val("rd_valid0", rd_valid0, ev0);
    check_val("rd_valid1", rd_valid1, ev1);
    if (ev0 || ev1) check_val("rd_data", rd_data, ed);
    if (rst) begin
      q.delete();
      m_prio = 0;
    end else if (winner >= 0) begin
      e.owner = winner;
      e.data  = rom_mem[exp_addr & ((1<<ADDR_W)-1)];
      e.due   = cyc + ROM_LAT;
      q.push_back(e);
      m_prio  = 1 - winner;
    end
    g0 = (winner == 0);
    g1 = (winner == 1);
    cyc++;
  endtask

  logic g0, g1;
  logic p0, p1;
  int   pa0, pa1;

  initial begin
    for (int i = 0; i < (1<<ADDR_W); i++) rom_mem[i] = DATA_W'($urandom);
    repeat (3) @(posedge clock);

    // idle after reset
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 0, g0, g1);
    // single read
    step(1, 'h005, 0, 0, 0, g0, g1);
    repeat (3) step(0, 0, 0, 0, 0, g0, g1);
    // contention, alternating grants
    for (int i = 0; i < 4; i++) step(1, 'h010, 1, 'h7FF, 0, g0, g1);
    repeat (3) step(0, 0, 0, 0, 0, g0, g1);
    // streaming requester 1, then a collision shows the pointer is back at 0
    for (int i = 0; i < 8; i++) step(0, 0, 1, i, 0, g0, g1);
    step(1, 'h123, 1, 'h456, 0, g0, g1);
    repeat (3) step(0, 0, 0, 0, 0, g0, g1);
    // reset mid-flight, requests held during reset must not be granted
    step(1, 'h0AA, 0, 0, 0, g0, g1);
    step(1, 'h0BB, 1, 'h0CC, 1, g0, g1);
    repeat (3) step(0, 0, 0, 0, 0, g0, g1);
    step(1, 'h001, 1, 'h002, 0, g0, g1);
    // address wrap
    step(1, 'h7FF, 0, 0, 0, g0, g1);
    step(1, 'h000, 0, 0, 0, g0, g1);
    repeat (3) step(0, 0, 0, 0, 0, g0, g1);

    // random traffic: each requester holds its request until granted
    p0 = 0; p1 = 0; pa0 = 0; pa1 = 0;
    for (int i = 0; i < 400; i++) begin
      logic rst;
      if (!p0 && $urandom_range(0, 2) != 0) begin p0 = 1; pa0 = $urandom_range(0, (1<<ADDR_W)-1); end
      if (!p1 && $urandom_range(0, 2) != 0) begin p1 = 1; pa1 = $urandom_range(0, (1<<ADDR_W)-1); end
      rst = ($urandom_range(0, 49) == 0);
      step(p0, pa0, p1, pa1, rst, g0, g1);
      if (g0) p0 = 0;
      if (g1) p1 = 0;
    end
    repeat (4) step(0, 0, 0, 0, 0, g0, g1);
    check_val("drain", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fm_rom_arbiter.md
Name: fm_rom_arbiter

Overview:
- Round-robin arbiter that shares the single-port FM waveform ROM (2048 x 14, registered address and registered output, 2-cycle read latency) between two read requesters, e.g. two FM channel players.
- Grants at most one read per clock, drives the ROM address, and tracks in-flight reads through a tag pipeline matched to the ROM latency.
- Returns each ROM word to the requester that issued it, qualified by a per-requester valid strobe.
- Sits between the channel sequencers and the FM ROM instance.

Parameters:
- ADDR_W, 11, ROM address width.
- DATA_W, 14, ROM data width.
- ROM_LAT, 2, clocks from address presented on rom_address to data valid on rom_q; must be >= 1.

Ports:
- clock  in  1  system clock; ROM uses the same clock.
- reset  in  1  synchronous, active-high.
- req0  in  1  requester 0 read request, level; held until granted.
- addr0  in  ADDR_W  requester 0 read address; stable while req0 is high.
- gnt0  out  1  requester 0 granted this cycle (combinational).
- req1  in  1  requester 1 read request.
- addr1  in  ADDR_W  requester 1 read address.
- gnt1  out  1  requester 1 granted this cycle (combinational).
- rom_address  out  ADDR_W  to the ROM address input.
- rom_q  in  DATA_W  from the ROM q output.
- rd_data  out  DATA_W  returned ROM word; equals rom_q.
- rd_valid0  out  1  rd_data belongs to requester 0 this cycle.
- rd_valid1  out  1  rd_data belongs to requester 1 this cycle.
- busy  out  1  one or more reads in flight (any tag pipe stage valid).

Behaviour:
- Clock and reset:
  - Single clock domain, clock.
  - reset is synchronous and active-high; all state changes only on the rising edge of clock.
- State:
  - prio: 1-bit round-robin pointer; 0 means requester 0 has priority.
  - tag pipe: ROM_LAT stages, each holding {valid, owner}.
- Reset values:
  - prio = 0; all tag pipe stages valid = 0.
  - Hence rd_valid0 = rd_valid1 = 0 and busy = 0 from the first cycle after reset asserts.
  - gnt0 and gnt1 are forced to 0 while reset is high, regardless of req0/req1.
- Grant logic (combinational, no wait state):
  - Only req0: gnt0 = 1.
  - Only req1: gnt1 = 1.
  - Both requesting: grant the requester indicated by prio.
  - Neither requesting: no grant.
  - gnt0 and gnt1 are never both 1.
- rom_address:
  - addr0 when gnt0, addr1 when gnt1, else 0.
  - Combinational; the ROM registers it internally.
- Pointer update:
  - On any grant, prio <= index of the requester not granted.
  - With no grant, prio holds.
- Tag pipe:
  - Stage 0 <= {gnt0 | gnt1, gnt1}; stage k <= stage k-1.
  - rd_valid0 = last.valid & ~last.owner; rd_valid1 = last.valid & last.owner.
  - A grant in cycle N yields exactly one valid strobe in cycle N+ROM_LAT, in the order granted.
- Throughput: one read per clock sustained; back-to-back grants to the same requester are allowed when the other is not requesting.
- Requester handshake: a requester sees gnt in the same cycle it presents req. It then either drops req or presents the next address in the following cycle; each req-high, gnt-high cycle counts as exactly one read.
- Reset mid-operation: in-flight reads are discarded. No rd_valid is produced for ROM data returning after reset, even though rom_q still changes.
- rd_data is always driven (passthrough of rom_q); it is meaningful only when a rd_valid is high.

Test Plan:
- Reset then idle: req0 = req1 = 0 for 10 cycles -> gnt0 = gnt1 = 0, rom_address = 0, rd_valid0/1 = 0, busy = 0.
- Single read: req0 = 1, addr0 = 0x005 for 1 cycle at cycle N -> gnt0 = 1 at N, rom_address = 0x005. At N+2, rd_valid0 = 1 and rd_data = ROM[5]; rd_valid1 = 0.
- Contention: req0 and req1 held high for 4 cycles, addr0 = 0x010, addr1 = 0x7FF, prio = 0 -> grants alternate 0, 1, 0, 1. rd_valid strobes alternate 0, 1, 0, 1 starting 2 cycles later, with rd_data = ROM[0x010], ROM[0x7FF], and so on.
- Streaming: req1 only, addr1 = 0, 1, 2, ..., 7 on consecutive cycles -> 8 consecutive gnt1, then 8 consecutive rd_valid1 with ROM[0..7]. prio = 0 afterwards.
- Reset mid-flight: grant a req0 read, assert reset the next cycle for 1 cycle -> no rd_valid0 appears, busy = 0, prio = 0.
- Wrap address: addr0 = 0x7FF then 0x000 back-to-back -> data ROM[0x7FF] then ROM[0x000] on consecutive rd_valid0 cycles.
